// File: rtl/delay_scan_ctrl.sv
// Tap-scan sequencer for the delay line: settles each tap, averages ref-to-delayed edge intervals, posts one result per tap.
// Optional input synchronizers are enabled with `define DELAY_SCAN_SYNC_EN.
module delay_scan_ctrl #(
   parameter int SEL_WIDTH     = 4,
   parameter int CNT_WIDTH     = 8,
   parameter int SETTLE_CYCLES = 16,
   parameter int AVG_LOG2      = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [SEL_WIDTH-1:0] sel_min,
   input  logic [SEL_WIDTH-1:0] sel_max,
   input  logic                 sig_ref,
   input  logic                 sig_dly,
   output logic [SEL_WIDTH-1:0] delay_sel,
   output logic                 busy,
   output logic                 meas_valid,
   output logic [SEL_WIDTH-1:0] meas_sel,
   output logic [CNT_WIDTH-1:0] meas_cnt,
   output logic                 meas_ovf,
   output logic                 done,
   output logic                 err
);
   localparam int ACC_W = CNT_WIDTH + AVG_LOG2;
   localparam int SCW   = $clog2(SETTLE_CYCLES + 1);
   localparam int NW    = AVG_LOG2 + 1;
   localparam logic [NW-1:0]        NLAST = NW'((2 ** AVG_LOG2) - 1);
   localparam logic [CNT_WIDTH-1:0] CMAX  = '1;
   localparam logic [SCW-1:0]       SLAST = SCW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, ARM, COUNT, RESULT, DONE} state_t;

   state_t               state, state_nxt;
   logic                 ref_s, dly_s, ref_q, dly_q, rr, rd;
   logic [SEL_WIDTH-1:0] sel_max_r;
   logic [SCW-1:0]       settle_cnt;
   logic [CNT_WIDTH-1:0] cnt, samp;
   logic [ACC_W-1:0]     acc;
   logic [NW-1:0]        nsamp;
   logic                 ovf_f, take, samp_ovf, cnt_clr, range_ok;

`ifdef DELAY_SCAN_SYNC_EN
   logic [1:0] ref_sync, dly_sync;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_sync <= '0;
         dly_sync <= '0;
      end else begin
         ref_sync <= {ref_sync[0], sig_ref};
         dly_sync <= {dly_sync[0], sig_dly};
      end
   end
   assign ref_s = ref_sync[1];
   assign dly_s = dly_sync[1];
`else
   assign ref_s = sig_ref;
   assign dly_s = sig_dly;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q <= 1'b0;
         dly_q <= 1'b0;
      end else begin
         ref_q <= ref_s;
         dly_q <= dly_s;
      end
   end

   assign rr       = ref_s & ~ref_q;
   assign rd       = dly_s & ~dly_q;
   assign range_ok = (sel_min <= sel_max);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      samp      = '0;
      samp_ovf  = 1'b0;
      cnt_clr   = 1'b0;
      case (state)
         IDLE:   if (start && range_ok) state_nxt = SETTLE;
         SETTLE: if (settle_cnt == SLAST) state_nxt = ARM;
         ARM: begin
            // Zero-delay tap: both edges land in the same cycle.
            if (rr && rd) begin
               take = 1'b1;
               if (nsamp == NLAST) state_nxt = RESULT;
            end else if (rr) begin
               cnt_clr   = 1'b1;
               state_nxt = COUNT;
            end
         end
         COUNT: begin
            if (rd) begin
               take     = 1'b1;
               samp     = (cnt == CMAX) ? CMAX : cnt + 1'b1;
               samp_ovf = (cnt == CMAX);
            end else if (cnt == CMAX) begin
               take     = 1'b1;
               samp     = CMAX;
               samp_ovf = 1'b1;
            end
            if (take) state_nxt = (nsamp == NLAST) ? RESULT : ARM;
         end
         RESULT: state_nxt = (delay_sel == sel_max_r) ? DONE : SETTLE;
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort && state != IDLE) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         delay_sel  <= '0;
         sel_max_r  <= '0;
         busy       <= 1'b0;
         meas_valid <= 1'b0;
         meas_sel   <= '0;
         meas_cnt   <= '0;
         meas_ovf   <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         settle_cnt <= '0;
         cnt        <= '0;
         acc        <= '0;
         nsamp      <= '0;
         ovf_f      <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         done       <= 1'b0;
         settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
         if (cnt_clr)              cnt <= '0;
         else if (state == COUNT)  cnt <= cnt + 1'b1;
         if (take) begin
            acc   <= acc + ACC_W'(samp);
            nsamp <= nsamp + 1'b1;
            ovf_f <= ovf_f | samp_ovf;
         end
         if (abort && state != IDLE) begin
            busy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  // Drop any partial tap left behind by an abort.
                  acc   <= '0;
                  nsamp <= '0;
                  ovf_f <= 1'b0;
                  if (start) begin
                     if (range_ok) begin
                        delay_sel <= sel_min;
                        sel_max_r <= sel_max;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                     end else begin
                        err  <= 1'b1;
                        done <= 1'b1;
                     end
                  end
               end
               RESULT: begin
                  meas_valid <= 1'b1;
                  meas_cnt   <= CNT_WIDTH'(acc >> AVG_LOG2);
                  meas_sel   <= delay_sel;
                  meas_ovf   <= ovf_f;
                  acc        <= '0;
                  nsamp      <= '0;
                  ovf_f      <= 1'b0;
                  if (delay_sel != sel_max_r) delay_sel <= delay_sel + 1'b1;
               end
               DONE: begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_delay_scan_ctrl.sv
// Scoreboard bench for delay_scan_ctrl: a behavioural delay line feeds the DUT, expected results are queued and checked by monitors.
module tb_delay_scan_ctrl;
   typedef struct packed {
      logic       kind;   // 0 = result, 1 = done
      logic [3:0] sel;
      logic [7:0] cnt;
      logic       ovf;
      logic       err;
      logic       gap;
   } exp_t;

   logic clk = 0, rst = 1, start0 = 0, start1 = 0, abort = 0;
   logic [3:0] sel_min = 0, sel_max = 0;
   logic sig_ref = 0, sig_dly = 0;
   logic [3:0] ds0, ms0, ds1, ms1;
   logic [7:0] mc0, mc1;
   logic busy0, mv0, mo0, done0, err0, busy1, mv1, mo1, done1, err1;

   int nrun = 0, nfail = 0;
   longint cyc = 0, last_mv0 = 0;
   int mode = 0, dconst = 3;
   exp_t q0[$], q1[$];

   delay_scan_ctrl u0 (.clk(clk), .rst(rst), .start(start0), .abort(abort), .sel_min(sel_min),
      .sel_max(sel_max), .sig_ref(sig_ref), .sig_dly(sig_dly), .delay_sel(ds0), .busy(busy0),
      .meas_valid(mv0), .meas_sel(ms0), .meas_cnt(mc0), .meas_ovf(mo0), .done(done0), .err(err0));

   delay_scan_ctrl #(.AVG_LOG2(1)) u1 (.clk(clk), .rst(rst), .start(start1), .abort(abort),
      .sel_min(sel_min), .sel_max(sel_max), .sig_ref(sig_ref), .sig_dly(sig_dly), .delay_sel(ds1),
      .busy(busy1), .meas_valid(mv1), .meas_sel(ms1), .meas_cnt(mc1), .meas_ovf(mo1),
      .done(done1), .err(err1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      nrun++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Behavioural PWM (period 40, high 20) and delay line driven by the tap select.
   initial begin
      int ph, idx;
      logic rnew, alt;
      logic [63:0] hist;
      ph = 0; alt = 0; hist = '0;
      forever begin
         @(negedge clk);
         ph   = (ph == 39) ? 0 : ph + 1;
         rnew = (ph < 20);
         if (rnew && !sig_ref) alt = ~alt;
         hist = {hist[62:0], rnew};
         case (mode)
            0: idx = dconst;
            1: idx = 2 * int'(ds0);
            3: idx = alt ? 3 : 2;
            default: idx = 3;
         endcase
         sig_ref = rnew;
         if (mode == 2 || (mode == 4 && ds0 == 4'd2)) sig_dly = 1'b0;
         else                                          sig_dly = hist[idx];
      end
   end

   always @(negedge clk) if (!rst) begin
      exp_t e;
      if (mv0) begin
         if (q0.size() == 0) chk("u0 unexpected meas_valid", 1, 0);
         else begin
            e = q0.pop_front();
            chk("u0 kind(result)", 0, int'(e.kind));
            chk("u0 meas_sel", int'(ms0), int'(e.sel));
            chk("u0 meas_cnt", int'(mc0), int'(e.cnt));
            chk("u0 meas_ovf", int'(mo0), int'(e.ovf));
         end
         last_mv0 = cyc;
      end
      if (done0) begin
         if (q0.size() == 0) chk("u0 unexpected done", 1, 0);
         else begin
            e = q0.pop_front();
            chk("u0 kind(done)", 1, int'(e.kind));
            chk("u0 err at done", int'(err0), int'(e.err));
            chk("u0 busy at done", int'(busy0), 0);
            if (e.gap) chk("u0 done gap", int'(cyc - last_mv0), 1);
         end
      end
   end

   always @(negedge clk) if (!rst) begin
      exp_t e;
      if (mv1) begin
         if (q1.size() == 0) chk("u1 unexpected meas_valid", 1, 0);
         else begin
            e = q1.pop_front();
            chk("u1 kind(result)", 0, int'(e.kind));
            chk("u1 meas_sel", int'(ms1), int'(e.sel));
            chk("u1 meas_cnt", int'(mc1), int'(e.cnt));
            chk("u1 meas_ovf", int'(mo1), int'(e.ovf));
         end
      end
      if (done1) begin
         if (q1.size() == 0) chk("u1 unexpected done", 1, 0);
         else begin
            e = q1.pop_front();
            chk("u1 kind(done)", 1, int'(e.kind));
            chk("u1 busy at done", int'(busy1), 0);
         end
      end
   end

   task automatic push_res(input int which, input int s, input int c, input int o);
      exp_t e;
      e = '{kind: 1'b0, sel: 4'(s), cnt: 8'(c), ovf: 1'(o), err: 1'b0, gap: 1'b0};
      if (which == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic push_done(input int which, input int er, input int gap);
      exp_t e;
      e = '{kind: 1'b1, sel: 4'd0, cnt: 8'd0, ovf: 1'b0, err: 1'(er), gap: 1'(gap)};
      if (which == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic pulse_start(input int which, input int lo, input int hi);
      @(negedge clk);
      sel_min = 4'(lo); sel_max = 4'(hi);
      if (which == 0) start0 = 1; else start1 = 1;
      @(negedge clk);
      start0 = 0; start1 = 0;
   endtask

   task automatic wait_q(input int which, input int budget);
      int n = 0;
      while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n >= budget) begin
         chk("scoreboard drain timeout", (which == 0) ? q0.size() : q1.size(), 0);
         q0.delete(); q1.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n, busy_seen;
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy0), 0);
      chk("reset outputs", int'({mv0, done0, err0, mo0}), 0);
      chk("reset delay_sel/meas", int'({ds0, ms0, mc0}), 0);
      rst = 0;
      repeat (2) @(negedge clk);

      // Fixed 3-cycle delay over taps 0..3.
      mode = 0; dconst = 3;
      for (int s = 0; s <= 3; s++) push_res(0, s, 3, 0);
      push_done(0, 0, 1);
      pulse_start(0, 0, 3);
      chk("busy during scan", int'(busy0), 1);
      wait_q(0, 3000);
      chk("busy after scan", int'(busy0), 0);
      chk("delay_sel last tap", int'(ds0), 3);
      chk("meas_cnt hold", int'(mc0), 3);
      chk("meas_sel hold", int'(ms0), 3);

      // Delay 2*sel over all taps; tap 0 uses the simultaneous-edge path.
      mode = 1;
      for (int s = 0; s <= 15; s++) push_res(0, s, 2 * s, 0);
      push_done(0, 0, 1);
      pulse_start(0, 0, 15);
      wait_q(0, 6000);
      chk("sweep delay_sel end", int'(ds0), 15);

      // Delayed signal stuck low: saturation.
      mode = 2;
      push_res(0, 5, 255, 1);
      push_done(0, 0, 1);
      pulse_start(0, 5, 5);
      wait_q(0, 3000);
      chk("ovf hold", int'(mo0), 1);

      // Inverted range.
      push_done(0, 1, 0);
      busy_seen = 0;
      pulse_start(0, 9, 4);
      for (int i = 0; i < 10; i++) begin
         if (busy0) busy_seen = 1;
         @(negedge clk);
      end
      wait_q(0, 100);
      chk("err sticky", int'(err0), 1);
      chk("busy never set on err", busy_seen, 0);

      // Abort inside COUNT at tap 2, then a clean rerun.
      mode = 4;
      push_res(0, 0, 3, 0);
      push_res(0, 1, 3, 0);
      pulse_start(0, 0, 7);
      chk("err cleared by valid start", int'(err0), 0);
      n = 0;
      while (ds0 != 4'd2 && n < 2000) begin @(negedge clk); n++; end
      chk("reach tap 2", int'(ds0), 2);
      repeat (70) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      @(negedge clk);
      chk("busy after abort", int'(busy0), 0);
      repeat (1500) @(negedge clk);
      chk("abort queue drained", q0.size(), 0);
      chk("delay_sel after abort", int'(ds0), 2);
      q0.delete();
      mode = 0;
      for (int s = 0; s <= 7; s++) push_res(0, s, 3, 0);
      push_done(0, 0, 1);
      pulse_start(0, 0, 7);
      wait_q(0, 4000);

      // Asynchronous reset in SETTLE.
      pulse_start(0, 5, 7);
      repeat (4) @(negedge clk);
      chk("busy before rst", int'(busy0), 1);
      chk("delay_sel before rst", int'(ds0), 5);
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("async rst busy", int'(busy0), 0);
      chk("async rst delay_sel", int'(ds0), 0);
      chk("async rst meas_cnt", int'(mc0), 0);
      chk("async rst meas_sel", int'(ms0), 0);
      q0.delete();
      @(negedge clk);
      rst = 0;
      repeat (2) @(negedge clk);

      // Alternating 2/3 delays with two-sample averaging truncate to 2.
      mode = 3;
      push_res(1, 0, 2, 0);
      push_done(1, 0, 0);
      pulse_start(1, 0, 0);
      wait_q(1, 2000);
      chk("u1 busy after scan", int'(busy1), 0);

      $display("[TB] %0d tests run, %0d failed", nrun, nfail);
      $finish;
   end
endmodule
